rf_wport_arbiter: RTL and testbench

- Shares the single register-file write port between the WB stage commit path (primary, in-order) and a long-latency writeback unit such as a divider (secondary, valid/ready).
- Secondary results are queued in a small FIFO and drained into idle port cycles.
- A starvation counter forces a WB hold so queued results always drain.
- Exports a pending-destination mask to issue-stage hazard logic.

---
 rtl/rf_wport_arbiter.sv | 107 ++++++++++
 tb/tb_rf_wport_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: the WB commit path has priority, while
// secondary long-latency results wait in a small FIFO with starvation relief.
module rf_wport_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wb_we,
  input  logic [4:0]                   wb_waddr,
  input  logic [31:0]                  wb_wdata,
  output logic                         wb_hold,
  input  logic                         lw_valid,
  input  logic [4:0]                   lw_waddr,
  input  logic [31:0]                  lw_wdata,
  output logic                         lw_ready,
  input  logic                         flush,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
  output logic [31:0]                  busy_mask
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic wb_use;
  logic pop;
  logic push;

  assign wb_hold  = (starve_cnt == SW'(STARVE_MAX)) && (count != '0);
  assign wb_use   = wb_we && (wb_waddr != 5'd0) && !wb_hold;
  assign pop      = !wb_use && (count != '0) && !flush;
  // A full FIFO refuses pushes even when the head pops in the same cycle.
  assign lw_ready = (count < CW'(DEPTH)) && !flush;
  assign push     = lw_valid && lw_ready && (lw_waddr != 5'd0);
  assign pend_cnt = count;

  // Same-cycle grant of the write port.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_waddr;
    rf_wdata = wb_wdata;
    if (wb_use) begin
      rf_we = 1'b1;
    end else if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = q_addr[head];
      rf_wdata = q_data[head];
    end
  end

  // Destinations of all valid queued entries, from registered state only.
  always_comb begin
    busy_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        busy_mask[q_addr[PW'(head + PW'(k))]] = 1'b1;
      end
    end
    busy_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= lw_waddr;
      q_data[tail] <= lw_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (pop || (count == '0)) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter: directed vector table, async-reset sequence,
// then random traffic against a queue-based reference model.
module tb_rf_wport_arbiter;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_hold;
  logic        lw_valid;
  logic [4:0]  lw_waddr;
  logic [31:0] lw_wdata;
  logic        lw_ready;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  pend_cnt;
  logic [31:0] busy_mask;

  int n_cmp = 0;
  int n_bad = 0;

  rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_hold(wb_hold),
    .lw_valid(lw_valid), .lw_waddr(lw_waddr), .lw_wdata(lw_wdata), .lw_ready(lw_ready),
    .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lw_valid;
    logic [4:0]  lw_waddr;
    logic [31:0] lw_wdata;
    logic        flush;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_hold;
    logic        e_ready;
    logic [1:0]  e_pend;
    logic [31:0] e_busy;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  int   m_starve;

  function automatic vec_t mk(logic wwe, logic [4:0] wa, logic [31:0] wd,
                              logic lv, logic [4:0] la, logic [31:0] ld, logic fl,
                              logic ewe, logic [4:0] ea, logic [31:0] ed,
                              logic eh, logic er, logic [1:0] ep, logic [31:0] eb);
    vec_t v;
    v.wb_we = wwe; v.wb_waddr = wa; v.wb_wdata = wd;
    v.lw_valid = lv; v.lw_waddr = la; v.lw_wdata = ld; v.flush = fl;
    v.e_we = ewe; v.e_waddr = ea; v.e_wdata = ed;
    v.e_hold = eh; v.e_ready = er; v.e_pend = ep; v.e_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic fl);
    wb_we = wwe; wb_waddr = wa; wb_wdata = wd;
    lw_valid = lv; lw_waddr = la; lw_wdata = ld; flush = fl;
  endtask

  task automatic check_all(input string tag, input logic ewe, input logic [4:0] ea,
                           input logic [31:0] ed, input logic eh, input logic er,
                           input logic [1:0] ep, input logic [31:0] eb);
    check({tag, ".rf_we"}, 32'(rf_we), 32'(ewe));
    check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(ea));
    check({tag, ".rf_wdata"}, rf_wdata, ed);
    check({tag, ".wb_hold"}, 32'(wb_hold), 32'(eh));
    check({tag, ".lw_ready"}, 32'(lw_ready), 32'(er));
    check({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(ep));
    check({tag, ".busy_mask"}, busy_mask, eb);
  endtask

  // One cycle of the reference model: compare outputs, then advance state.
  task automatic model_cycle(input string tag);
    int          sz;
    logic        hold, use_wb, pop, rdy;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed, eb;
    sz     = mq.size();
    hold   = (m_starve == STARVE_MAX) && (sz > 0);
    use_wb = wb_we && (wb_waddr != 5'd0) && !hold;
    pop    = !use_wb && (sz > 0) && !flush;
    rdy    = (sz < DEPTH) && !flush;
    eb     = '0;
    foreach (mq[i]) eb[mq[i].addr] = 1'b1;
    eb[0]  = 1'b0;
    if (use_wb)   begin ewe = 1'b1; ea = wb_waddr;   ed = wb_wdata;   end
    else if (pop) begin ewe = 1'b1; ea = mq[0].addr; ed = mq[0].data; end
    else          begin ewe = 1'b0; ea = wb_waddr;   ed = wb_wdata;   end
    @(negedge clk);
    check_all(tag, ewe, ea, ed, hold, rdy, 2'(sz), eb);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_starve = 0;
    end else begin
      if (pop) mq.delete(0);
      if (lw_valid && rdy && (lw_waddr != 5'd0)) mq.push_back('{lw_waddr, lw_wdata});
      if (pop || sz == 0) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset release, single push, starvation, flush, discard, WB-to-r0 drain.
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,0,0,          1,5,32'hDEADBEEF,0,      0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 1,5,32'hDEADBEEF,0,1,1,32'h20));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));
    vecs.push_back(mk(1,3,32'h33,     1,7,32'h77,0,            1,3,32'h33,     0,1,0,0));
    vecs.push_back(mk(1,3,32'h33,     1,9,32'h99,0,            1,3,32'h33,     0,1,1,32'h80));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,3,32'h33,   0,0,0,0,                 1,3,32'h33,     0,0,2,32'h280));
    vecs.push_back(mk(1,3,32'h33,     1,11,32'hBB,0,           1,7,32'h77,     1,0,2,32'h280));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,3,32'h33,   0,0,0,0,                 1,3,32'h33,     0,1,1,32'h200));
    vecs.push_back(mk(1,3,32'h33,     0,0,0,0,                 1,9,32'h99,     1,1,1,32'h200));
    vecs.push_back(mk(1,3,32'h33,     0,0,0,0,                 1,3,32'h33,     0,1,0,0));
    vecs.push_back(mk(1,3,32'h33,     1,7,32'h77,0,            1,3,32'h33,     0,1,0,0));
    vecs.push_back(mk(1,3,32'h33,     1,9,32'h99,0,            1,3,32'h33,     0,1,1,32'h80));
    vecs.push_back(mk(1,1,32'h11,     1,12,32'hCC,1,           1,1,32'h11,     0,0,2,32'h280));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,0,0,          1,4,32'h44,0,            0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,2,32'h22,     0,0,0,1,                 0,2,32'h22,     0,0,1,32'h10));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,0,0,          1,0,32'h55,0,            0,0,0,          0,1,0,0));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));
    vecs.push_back(mk(1,8,32'h88,     1,6,32'h66,0,            1,8,32'h88,     0,1,0,0));
    vecs.push_back(mk(1,0,32'h1234,   0,0,0,0,                 1,6,32'h66,     0,1,1,32'h40));
    vecs.push_back(mk(0,0,0,          0,0,0,0,                 0,0,0,          0,1,0,0));

    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].wb_we, vecs[i].wb_waddr, vecs[i].wb_wdata,
            vecs[i].lw_valid, vecs[i].lw_waddr, vecs[i].lw_wdata, vecs[i].flush);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
                vecs[i].e_hold, vecs[i].e_ready, vecs[i].e_pend, vecs[i].e_busy);
      @(posedge clk);
      #1;
    end

    // Async reset mid-cycle with two entries queued.
    drive(1, 3, 32'h33, 1, 7, 32'h77, 0);
    @(posedge clk); #1;
    drive(1, 3, 32'h33, 1, 9, 32'h99, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("arst.pend_before", 32'(pend_cnt), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check_all("arst.during", 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all($sformatf("arst.after%0d", i), 0, 0, 0, 0, 1, 0, 0);
    end
    @(posedge clk); #1;

    // Random traffic against the reference model.
    mq.delete();
    m_starve = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] mbusy;
      logic [4:0]  wa;
      logic        wwe;
      mbusy = '0;
      foreach (mq[i]) mbusy[mq[i].addr] = 1'b1;
      wa  = 5'($urandom_range(0, 31));
      wwe = ($urandom_range(0, 99) < 50) && !mbusy[wa];
      drive(wwe, wa, $urandom,
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 3);
      model_cycle($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
